// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex driver for a bank of seven-segment
// digits. A frame (nibbles, decimal points, blanks) is staged in a pending
// register and committed only at a frame boundary. This keeps every displayed
// frame consistent. All outputs are registered.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_done
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  // Deasserted level of every output: high when the outputs are active-low.
  localparam logic POL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // Hex nibble to on-pattern, bit0 = segment A ... bit6 = segment G.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  logic [TW-1:0]           r_tick;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_dig;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_act_dig;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank;
  logic                    r_bnd_d;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  logic                    w_tc;
  logic                    w_boundary;
  logic [3:0]              w_nib;
  logic                    w_dp_on;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_an_on;
  logic [6:0]              w_seg_nxt;
  logic                    w_dp_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;

  assign w_tc       = (r_tick == TICK_LAST);
  assign w_boundary = w_tc && (r_idx == IDX_LAST);

  // Select the active-frame fields of the digit currently being scanned.
  always_comb begin
    w_nib   = 4'h0;
    w_dp_on = 1'b0;
    w_blank = 1'b0;
    w_an_on = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_nib      = (r_idx == IW'(k)) ? r_act_dig[4*k +: 4] : w_nib;
      w_dp_on    = (r_idx == IW'(k)) ? r_act_dp[k]         : w_dp_on;
      w_blank    = (r_idx == IW'(k)) ? r_act_blank[k]      : w_blank;
      w_an_on[k] = (r_idx == IW'(k));
    end
  end

  // Decode the selected digit and apply output polarity; a blank digit goes fully dark.
  always_comb begin
    w_seg_nxt = {7{POL}};
    w_dp_nxt  = POL;
    w_an_nxt  = {NUM_DIGITS{POL}};
    if (!w_blank) begin
      w_seg_nxt = hex_to_seg(w_nib) ^ {7{POL}};
      w_dp_nxt  = w_dp_on ^ POL;
      w_an_nxt  = w_an_on ^ {NUM_DIGITS{POL}};
    end else begin
      w_seg_nxt = {7{POL}};
      w_dp_nxt  = POL;
      w_an_nxt  = {NUM_DIGITS{POL}};
    end
  end

  // Refresh tick counter and scan index, which advances on each terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick <= '0;
      r_idx  <= '0;
    end else if (w_tc) begin
      r_tick <= '0;
      r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end else begin
      r_tick <= r_tick + TW'(1);
    end
  end

  // Stage loads in the pending frame and commit them only at a frame boundary.
  // A load on the boundary cycle bypasses the pending frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_dig   <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pend_valid <= 1'b0;
      r_act_dig    <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
    end else if (w_boundary) begin
      if (load) begin
        r_act_dig    <= digits_in;
        r_act_dp     <= dp_in;
        r_act_blank  <= blank_in;
        r_pend_valid <= 1'b0;
      end else if (r_pend_valid) begin
        r_act_dig    <= r_pend_dig;
        r_act_dp     <= r_pend_dp;
        r_act_blank  <= r_pend_blank;
        r_pend_valid <= 1'b0;
      end
    end else if (load) begin
      r_pend_dig   <= digits_in;
      r_pend_dp    <= dp_in;
      r_pend_blank <= blank_in;
      r_pend_valid <= 1'b1;
    end
  end

  // Output register stage. frame_done is delayed twice so it lines up with digit 0's first output cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg        <= {7{POL}};
      r_dp         <= POL;
      r_an         <= {NUM_DIGITS{POL}};
      r_bnd_d      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_an         <= w_an_nxt;
      r_bnd_d      <= w_boundary;
      r_frame_done <= r_bnd_d;
    end
  end

  assign seg_o      = r_seg;
  assign dp_o       = r_dp;
  assign an_o       = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three configurations share the stimulus and are
// compared every cycle against a frame/timing model, plus directed constants.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] dig_in;
  logic [7:0]  dp_in;
  logic [7:0]  bl_in;
  logic        load;

  logic [6:0] seg0, seg1, seg2;
  logic       dp0, dp1, dp2;
  logic [7:0] an0;
  logic [0:0] an1;
  logic [3:0] an2;
  logic       fd0, fd1, fd2;

  seg7_scan_driver #(.NUM_DIGITS(8), .REFRESH_DIV(4), .ACTIVE_LOW(1)) u_dut0 (
    .clk(clk), .rst(rst), .digits_in(dig_in), .dp_in(dp_in), .blank_in(bl_in),
    .load(load), .seg_o(seg0), .dp_o(dp0), .an_o(an0), .frame_done(fd0));
  seg7_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(1), .ACTIVE_LOW(1)) u_dut1 (
    .clk(clk), .rst(rst), .digits_in(dig_in[3:0]), .dp_in(dp_in[0:0]), .blank_in(bl_in[0:0]),
    .load(load), .seg_o(seg1), .dp_o(dp1), .an_o(an1), .frame_done(fd1));
  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(3), .ACTIVE_LOW(0)) u_dut2 (
    .clk(clk), .rst(rst), .digits_in(dig_in[15:0]), .dp_in(dp_in[3:0]), .blank_in(bl_in[3:0]),
    .load(load), .seg_o(seg2), .dp_o(dp2), .an_o(an2), .frame_done(fd2));

  int pn [3] = '{8, 1, 4};
  int pr [3] = '{4, 1, 3};
  int pa [3] = '{1, 1, 0};
  logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: cycles since reset, displayed frame, latest undisplayed load.
  int          mc    [3];
  logic [31:0] adig  [3];
  logic [7:0]  adp   [3];
  logic [7:0]  abl   [3];
  logic        pv    [3];
  logic [31:0] pdig  [3];
  logic [7:0]  pdp   [3];
  logic [7:0]  pbl   [3];
  logic        bprev [3];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict outputs from the model, advance the model, clock, compare.
  task automatic cyc();
    logic [6:0]  es [3];
    logic        ed [3];
    logic [7:0]  ea [3];
    logic        ef [3];
    logic [8:0]  msk;
    logic [31:0] sh;
    logic [6:0]  on;
    logic [7:0]  anon;
    logic        dpon;
    logic        al;
    logic        b;
    int          d;
    for (int k = 0; k < 3; k++) begin
      msk = (9'd1 << pn[k]) - 9'd1;
      al  = (pa[k] != 0);
      if (rst) begin
        es[k] = al ? 7'h7F : 7'h00;
        ed[k] = al;
        ea[k] = al ? msk[7:0] : 8'h00;
        ef[k] = 1'b0;
      end else begin
        d    = (mc[k] / pr[k]) % pn[k];
        sh   = adig[k] >> (4 * d);
        on   = segtab[sh[3:0]];
        anon = 8'd1 << d;
        dpon = adp[k][d];
        if (abl[k][d]) begin
          on   = 7'h00;
          anon = 8'h00;
          dpon = 1'b0;
        end
        es[k] = al ? ~on : on;
        ed[k] = al ? ~dpon : dpon;
        ea[k] = al ? (~anon & msk[7:0]) : anon;
        ef[k] = bprev[k];
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mc[k] = 0; adig[k] = '0; adp[k] = '0; abl[k] = '0;
        pv[k] = 1'b0; pdig[k] = '0; pdp[k] = '0; pbl[k] = '0; bprev[k] = 1'b0;
      end else begin
        b = ((mc[k] % (pn[k] * pr[k])) == (pn[k] * pr[k] - 1));
        if (b && load) begin
          adig[k] = dig_in; adp[k] = dp_in; abl[k] = bl_in; pv[k] = 1'b0;
        end else if (b && pv[k]) begin
          adig[k] = pdig[k]; adp[k] = pdp[k]; abl[k] = pbl[k]; pv[k] = 1'b0;
        end else if (!b && load) begin
          pdig[k] = dig_in; pdp[k] = dp_in; pbl[k] = bl_in; pv[k] = 1'b1;
        end
        bprev[k] = b;
        mc[k]++;
      end
    end
    @(posedge clk);
    #1;
    chk("i0.seg", {1'b0, seg0}, {1'b0, es[0]});
    chk("i0.dp",  {7'b0, dp0},  {7'b0, ed[0]});
    chk("i0.an",  an0,          ea[0]);
    chk("i0.fd",  {7'b0, fd0},  {7'b0, ef[0]});
    chk("i1.seg", {1'b0, seg1}, {1'b0, es[1]});
    chk("i1.dp",  {7'b0, dp1},  {7'b0, ed[1]});
    chk("i1.an",  {7'b0, an1},  ea[1]);
    chk("i1.fd",  {7'b0, fd1},  {7'b0, ef[1]});
    chk("i2.seg", {1'b0, seg2}, {1'b0, es[2]});
    chk("i2.dp",  {7'b0, dp2},  {7'b0, ed[2]});
    chk("i2.an",  {4'b0, an2},  ea[2]);
    chk("i2.fd",  {7'b0, fd2},  {7'b0, ef[2]});
  endtask

  // Advance until instance 0's next state to be clocked is slot-cycle x of its 32-cycle frame.
  task automatic goto(input int x);
    for (int g = 0; g < 64; g++) begin
      if ((mc[0] % 32) == x) break;
      cyc();
    end
  endtask

  task automatic load_frame(input logic [31:0] d, input logic [7:0] p, input logic [7:0] bl);
    dig_in = d; dp_in = p; bl_in = bl; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    int fcnt;
    int zero = 0;
    rst = 1'b1; dig_in = '0; dp_in = '0; bl_in = '0; load = 1'b0;
    for (int k = 0; k < 3; k++) mc[k] = 0;

    // Reset: everything dark.
    repeat (3) cyc();
    chk("rst.an0",  an0, 8'hFF);
    chk("rst.seg0", {1'b0, seg0}, 8'h7F);
    chk("rst.an2",  {4'b0, an2}, 8'h00);
    chk("rst.seg2", {1'b0, seg2}, 8'h00);
    rst = 1'b0;

    // Scan order and frame_done period.
    load_frame(32'h76543210, 8'h00, 8'h00);
    goto(0); cyc();
    chk("scan.an0", an0, 8'hFE);
    chk("scan.fd0", {7'b0, fd0}, 8'h01);
    for (int j = 1; j < 8; j++) begin
      goto(4 * j); cyc();
      chk("scan.an", an0, 8'hFF ^ (8'd1 << j));
      chk("scan.seg", {1'b0, seg0}, {1'b0, ~segtab[j]});
    end
    fcnt = 0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      if (fd0) fcnt++;
    end
    chk("fd.count", fcnt[7:0], 8'd2);

    // Decode of the upper codes.
    goto(10); load_frame(32'hFEDCBA98, 8'h00, 8'h00);
    goto(0);  cyc(); chk("dec.d0", {1'b0, seg0}, 8'h00);
    goto(16); cyc(); chk("dec.d4", {1'b0, seg0}, 8'h46);
    goto(28); cyc(); chk("dec.d7", {1'b0, seg0}, 8'h0E);

    // Tear-free load while digit 3 is shown.
    goto(12); load_frame(32'h76543210, 8'h00, 8'h00);
    goto(16); cyc(); chk("tear.old4", {1'b0, seg0}, 8'h46);
    goto(28); cyc(); chk("tear.old7", {1'b0, seg0}, 8'h0E);
    goto(0);  cyc(); chk("tear.new0", {1'b0, seg0}, 8'h40);
    chk("tear.fd", {7'b0, fd0}, 8'h01);
    goto(5);  load_frame(32'h11111111, 8'h00, 8'h00);
    goto(20); load_frame(32'h22222222, 8'h00, 8'h00);
    goto(0);  cyc(); chk("twoload", {1'b0, seg0}, 8'h24);

    // Load on the boundary cycle wins over an earlier pending load, and nothing stays pending.
    goto(10); load_frame(32'h33333333, 8'h00, 8'h00);
    goto(31); load_frame(32'h44444444, 8'h00, 8'h00);
    cyc(); chk("coin.d0", {1'b0, seg0}, 8'h19);
    goto(0); cyc(); chk("coin.next", {1'b0, seg0}, 8'h19);

    // Blank and decimal points.
    goto(10); load_frame(32'h44444444, 8'h81, 8'h02);
    goto(0);  cyc(); chk("dp.s0", {7'b0, dp0}, 8'h00); chk("an.s0", an0, 8'hFE);
    goto(4);  cyc(); chk("blank.an", an0, 8'hFF); chk("blank.seg", {1'b0, seg0}, 8'h7F);
    chk("blank.dp", {7'b0, dp0}, 8'h01);
    goto(8);  cyc(); chk("dp.s2", {7'b0, dp0}, 8'h01);
    goto(28); cyc(); chk("dp.s7", {7'b0, dp0}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("n1.an", {7'b0, an1}, 8'h00);
      chk("n1.fd", {7'b0, fd1}, 8'h01);
    end

    // Reset mid-frame discards the pending load.
    goto(10); load_frame(32'h55555555, 8'h00, 8'h00);
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    goto(31); cyc(); cyc();
    chk("rstpend.seg", {1'b0, seg0}, 8'h40);
    chk("rstpend.fd",  {7'b0, fd0}, 8'h01);

    // Randomised loads and occasional resets against the model.
    for (int i = 0; i < 800; i++) begin
      load   = (($urandom % 8) == zero);
      rst    = (($urandom % 150) == zero);
      dig_in = $urandom;
      dp_in  = 8'($urandom);
      bl_in  = 8'($urandom) & 8'($urandom);
      cyc();
    end
    load = 1'b0; rst = 1'b0;
    repeat (40) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
